sd_sector_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single MiST sector-transfer port between several sector-level requesters. These are the emulated disk and SD-card images behind `sd_card`, plus future image loaders. It sits between the requesters and `mist_io`/`sd_card` in the `clk_sys` domain. It latches one request at a time, drives `sd_rd`/`sd_wr`/`sd_lba`, and routes the 512-byte buffer traffic to the owning requester only. It also aborts requests the IO controller never acknowledges.

---
 rtl/sd_sector_arbiter.sv | 130 +++++++++++++
 tb/tb_sd_sector_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_arbiter.sv
// Round-robin owner of the single MiST sector port: grants one requester at a time,
// drives sd_rd/sd_wr/sd_lba, routes buffer strobes to the owner, aborts unacknowledged requests.
module sd_sector_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 2700000
) (
    input  logic                 clk_sys_i,
    input  logic                 reset_n_i,
    input  logic [NREQ-1:0]      rq_rd_i,
    input  logic [NREQ-1:0]      rq_wr_i,
    input  logic [NREQ*32-1:0]   rq_lba_i,
    input  logic [NREQ*8-1:0]    rq_buff_din_i,
    output logic [NREQ-1:0]      rq_busy_o,
    output logic [NREQ-1:0]      rq_done_o,
    output logic [NREQ-1:0]      rq_err_o,
    output logic [NREQ-1:0]      rq_buff_wr_o,
    output logic [31:0]          sd_lba_o,
    output logic                 sd_rd_o,
    output logic                 sd_wr_o,
    input  logic                 sd_ack_i,
    input  logic                 sd_buff_wr_i,
    output logic [7:0]           sd_buff_din_o
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

    state_t                  state_q;
    logic [OW-1:0]           owner_q, rr_ptr_q, grant_d, next_ptr;
    logic [CW-1:0]           cnt_q;
    logic [31:0]             sd_lba_q;
    logic                    sd_rd_q, sd_wr_q;
    logic [NREQ-1:0]         busy_q, done_q, err_q, owner_oh;
    logic [NREQ-1:0]         pend_d;
    logic [2*NREQ-1:0]       rot_d;
    logic [OW:0]             off_d, sum_d;
    logic                    found_d;
    logic [NREQ-1:0][31:0]   lba_a;
    logic [NREQ-1:0][7:0]    din_a;

    assign lba_a    = rq_lba_i;
    assign din_a    = rq_buff_din_i;
    assign owner_oh = NREQ'(1) << owner_q;
    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    // Rotate pending so bit 0 is rr_ptr; the lowest set bit is the winner's distance from it.
    always_comb begin
        pend_d  = rq_rd_i | rq_wr_i;
        rot_d   = {pend_d, pend_d} >> rr_ptr_q;
        found_d = 1'b0;
        off_d   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_d[j]) begin
                found_d = 1'b1;
                off_d   = (OW+1)'(j);
            end
        end
        sum_d   = {1'b0, rr_ptr_q} + off_d;
        grant_d = (sum_d >= (OW+1)'(NREQ)) ? OW'(sum_d - (OW+1)'(NREQ)) : OW'(sum_d);
    end

    always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            sd_lba_q <= '0;
            sd_rd_q  <= 1'b0;
            sd_wr_q  <= 1'b0;
            busy_q   <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        owner_q  <= grant_d;
                        sd_lba_q <= lba_a[grant_d];
                        sd_rd_q  <= rq_rd_i[grant_d];
                        sd_wr_q  <= ~rq_rd_i[grant_d];
                        busy_q   <= NREQ'(1) << grant_d;
                        cnt_q    <= '0;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An ack present on entry counts, so it takes priority over the timeout.
                    if (sd_ack_i) begin
                        sd_rd_q <= 1'b0;
                        sd_wr_q <= 1'b0;
                        state_q <= XFER;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        sd_rd_q  <= 1'b0;
                        sd_wr_q  <= 1'b0;
                        err_q    <= owner_oh;
                        done_q   <= owner_oh;
                        busy_q   <= '0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                XFER: begin
                    if (!sd_ack_i) state_q <= DONE;
                end
                DONE: begin
                    done_q   <= owner_oh;
                    busy_q   <= '0;
                    rr_ptr_q <= next_ptr;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rq_busy_o     = busy_q;
    assign rq_done_o     = done_q;
    assign rq_err_o      = err_q;
    assign sd_lba_o      = sd_lba_q;
    assign sd_rd_o       = sd_rd_q;
    assign sd_wr_o       = sd_wr_q;
    assign rq_buff_wr_o  = (state_q == XFER && sd_buff_wr_i) ? owner_oh : '0;
    assign sd_buff_din_o = (state_q != IDLE) ? din_a[owner_q] : 8'h00;
endmodule

// File: tb/tb_sd_sector_arbiter.sv
// Directed bench for sd_sector_arbiter: a transaction-level reference checked every cycle,
// a small mist_io responder, and literal expectations for each scenario.
module tb_sd_sector_arbiter;
    localparam int NREQ = 2;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [NREQ-1:0] rq_rd = '0, rq_wr = '0;
    logic [NREQ-1:0][31:0] rq_lba = '0;
    logic [NREQ-1:0][7:0]  rq_din = '0;
    logic [NREQ-1:0] busy, done, err, bwr_o;
    logic [31:0] sd_lba;
    logic sd_rd, sd_wr;
    logic ack = 1'b0;
    logic [7:0] sd_din;

    int errors = 0, checks = 0;

    sd_sector_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk_sys_i(clk), .reset_n_i(rst_n),
        .rq_rd_i(rq_rd), .rq_wr_i(rq_wr), .rq_lba_i(rq_lba), .rq_buff_din_i(rq_din),
        .rq_busy_o(busy), .rq_done_o(done), .rq_err_o(err), .rq_buff_wr_o(bwr_o),
        .sd_lba_o(sd_lba), .sd_rd_o(sd_rd), .sd_wr_o(sd_wr),
        .sd_ack_i(ack), .sd_buff_wr_i(ack), .sd_buff_din_o(sd_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // mist_io responder: ack on the 4th cycle of a strobe, hold it ack_len cycles;
    // every ack cycle carries a buffer write.
    bit ack_en = 1'b1;
    int ack_len = 8;
    int mdly = 0, mlen = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack = 1'b0; mdly = 0; mlen = 0;
        end else if (ack) begin
            mlen++;
            if (mlen >= ack_len) ack = 1'b0;
        end else if ((sd_rd || sd_wr) && ack_en) begin
            mdly++;
            if (mdly == 4) begin ack = 1'b1; mdly = 0; mlen = 0; end
        end else begin
            mdly = 0;
        end
    end

    // Reference: who owns the port and which phase of its sector it is in.
    int m_own = -1, m_ptr = 0, m_wait = 0, m_last = 0;
    bit m_acked = 0, m_closing = 0, m_isrd = 0, m_done = 0, m_err = 0;
    logic [31:0] m_lba = '0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = -1; m_ptr = 0; m_lba = '0; m_done = 0; m_err = 0;
            m_acked = 0; m_closing = 0; m_wait = 0;
        end else begin
            m_done = 0; m_err = 0;
            if (m_own < 0) begin
                for (int k = 0; k < NREQ; k++) begin
                    int i;
                    i = (m_ptr + k) % NREQ;
                    if (m_own < 0 && (rq_rd[i] || rq_wr[i])) begin
                        m_own = i; m_lba = rq_lba[i]; m_isrd = rq_rd[i];
                        m_wait = 0; m_acked = 0; m_closing = 0;
                    end
                end
            end else if (m_closing) begin
                m_done = 1; m_last = m_own; m_ptr = (m_own + 1) % NREQ; m_own = -1;
            end else if (!m_acked) begin
                if (ack) m_acked = 1;
                else if (m_wait == TMO - 1) begin
                    m_done = 1; m_err = 1; m_last = m_own; m_ptr = (m_own + 1) % NREQ; m_own = -1;
                end else m_wait++;
            end else if (!ack) begin
                m_closing = 1;
            end
        end
    end

    // Per-cycle compare plus monitors for strobe lengths, pulse counts and grant order.
    int rd_run = 0, last_rd = 0, wr_run = 0, last_wr = 0, wr_total = 0;
    int bwr_cnt[NREQ], done_cnt[NREQ], err_cnt[NREQ];
    int gl[$];
    logic [NREQ-1:0] busy_prev = '0;
    initial begin
        for (int i = 0; i < NREQ; i++) begin bwr_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0; end
        forever begin
            logic [NREQ-1:0] e_busy, e_done, e_err, e_bwr;
            logic [7:0] e_din;
            @(posedge clk); #2;
            e_busy = (m_own >= 0) ? (NREQ'(1) << m_own) : '0;
            e_done = m_done ? (NREQ'(1) << m_last) : '0;
            e_err  = m_err  ? (NREQ'(1) << m_last) : '0;
            e_bwr  = (m_own >= 0 && m_acked && !m_closing && ack) ? (NREQ'(1) << m_own) : '0;
            e_din  = 8'h00;
            for (int i = 0; i < NREQ; i++) if (i == m_own) e_din = rq_din[i];
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, e_err);
            chk("buff_wr", bwr_o, e_bwr);
            chk("sd_lba", sd_lba, m_lba);
            chk("sd_rd", sd_rd, (m_own >= 0 && !m_acked && m_isrd));
            chk("sd_wr", sd_wr, (m_own >= 0 && !m_acked && !m_isrd));
            chk("sd_buff_din", sd_din, e_din);

            if (sd_rd) rd_run++; else if (rd_run > 0) begin last_rd = rd_run; rd_run = 0; end
            if (sd_wr) begin wr_run++; wr_total++; end
            else if (wr_run > 0) begin last_wr = wr_run; wr_run = 0; end
            for (int i = 0; i < NREQ; i++) begin
                bwr_cnt[i] += int'(bwr_o[i]);
                done_cnt[i] += int'(done[i]);
                err_cnt[i] += int'(err[i]);
                if (busy_prev == '0 && busy[i]) gl.push_back(i);
            end
            busy_prev = busy;
        end
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic wait_done(input int idx, input int bound);
        int n;
        n = 0;
        while (done[idx] !== 1'b1 && n < bound) begin tick(); n++; end
        chk($sformatf("done_wait%0d", idx), 32'(n < bound), 1);
        rq_rd[idx] = 1'b0;
        rq_wr[idx] = 1'b0;
    endtask

    task automatic wait_bwr(input int idx, input int bound);
        int n;
        n = 0;
        while (bwr_o[idx] !== 1'b1 && n < bound) begin tick(); n++; end
        chk($sformatf("xfer_wait%0d", idx), 32'(n < bound), 1);
    endtask

    function automatic int gat(input int k);
        return (gl.size() > k) ? gl[k] : 255;
    endfunction

    initial begin
        int b0, b1, d0, e0, e1, w0, g0;
        int served[NREQ], rearm[NREQ];
        #1 rst_n = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_lba", sd_lba, 0);
        chk("rst_strobes", {sd_rd, sd_wr}, 0);
        rst_n = 1'b1;
        tick();

        // Single read on requester 0, full 512-byte sector.
        ack_len = 512;
        b0 = bwr_cnt[0]; b1 = bwr_cnt[1]; d0 = done_cnt[0]; e0 = err_cnt[0];
        rq_lba[0] = 32'h0000_0123;
        rq_rd[0] = 1'b1;
        wait_done(0, 1200);
        chk("rd_lba", sd_lba, 32'h123);
        chk("rd_strobe_len", last_rd, 4);
        chk("rd_bwr0_cnt", bwr_cnt[0] - b0, 512);
        chk("rd_bwr1_cnt", bwr_cnt[1] - b1, 0);
        chk("rd_done_cnt", done_cnt[0] - d0, 1);
        chk("rd_err_cnt", err_cnt[0] - e0, 0);
        tick();
        ack_len = 8;

        // Single write on requester 1.
        rq_din[0] = 8'h3C; rq_din[1] = 8'hA5; rq_lba[1] = 32'd7;
        w0 = wr_total;
        rq_wr[1] = 1'b1;
        wait_bwr(1, 50);
        chk("wr_xfer_din", sd_din, 8'hA5);
        wait_done(1, 100);
        chk("wr_strobe_len", last_wr, 4);
        chk("wr_strobe_cnt", wr_total - w0, 4);
        tick();
        chk("wr_idle_din", sd_din, 8'h00);
        chk("wr_lba_hold", sd_lba, 32'd7);

        // Simultaneous requests, each re-requesting right after its done.
        g0 = gl.size();
        rq_lba[0] = 32'h10; rq_lba[1] = 32'h20;
        for (int i = 0; i < NREQ; i++) begin served[i] = 0; rearm[i] = 0; end
        rq_rd = 2'b11;
        for (int c = 0; c < 400 && !(served[0] == 2 && served[1] == 2); c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin served[i]++; rq_rd[i] = 1'b0; rearm[i] = 1; end
                else if (rearm[i] != 0) begin
                    rearm[i] = 0;
                    if (served[i] < 2) rq_rd[i] = 1'b1;
                end
            end
        end
        chk("rr_served", served[0] + served[1], 4);
        chk("rr_g0", gat(g0), 0);
        chk("rr_g1", gat(g0 + 1), 1);
        chk("rr_g2", gat(g0 + 2), 0);
        chk("rr_g3", gat(g0 + 3), 1);
        tick();

        // Timeout: no ack for requester 0, then a normal request on 1.
        ack_en = 1'b0;
        e0 = err_cnt[0]; e1 = err_cnt[1];
        rq_lba[0] = 32'h55;
        rq_rd[0] = 1'b1;
        wait_done(0, 60);
        chk("to_err_pulse", err[0], 1);
        chk("to_busy", busy, 0);
        chk("to_strobe_len", last_rd, TMO);
        ack_en = 1'b1;
        rq_lba[1] = 32'h66;
        rq_rd[1] = 1'b1;
        wait_done(1, 100);
        chk("to_err0_cnt", err_cnt[0] - e0, 1);
        chk("to_err1_cnt", err_cnt[1] - e1, 0);
        chk("to_next_lba", sd_lba, 32'h66);
        tick();

        // Both rd and wr from requester 1: only a read strobe.
        w0 = wr_total;
        rq_rd[1] = 1'b1; rq_wr[1] = 1'b1;
        wait_done(1, 100);
        chk("both_no_wr", wr_total - w0, 0);
        chk("both_rd_len", last_rd, 4);
        tick();

        // Requester 0 withdraws during XFER: the sector still completes.
        d0 = done_cnt[0];
        rq_rd[0] = 1'b1;
        wait_bwr(0, 50);
        rq_rd[0] = 1'b0;
        wait_done(0, 100);
        chk("wd_done_cnt", done_cnt[0] - d0, 1);
        tick();

        // Reset during requester 1's XFER; afterwards arbitration restarts at index 0.
        rq_lba[1] = 32'h77;
        rq_rd[1] = 1'b1;
        wait_bwr(1, 50);
        #2 rst_n = 1'b0;
        rq_rd[1] = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_buff_wr", bwr_o, 0);
        chk("mr_strobes", {sd_rd, sd_wr}, 0);
        chk("mr_lba", sd_lba, 0);
        chk("mr_din", sd_din, 0);
        chk("mr_pulses", {done, err}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        g0 = gl.size();
        rq_lba[0] = 32'h88; rq_lba[1] = 32'h99;
        rq_rd = 2'b11;
        wait_done(0, 100);
        chk("mr_first_grant", gat(g0), 0);
        wait_done(1, 100);
        chk("mr_second_grant", gat(g0 + 1), 1);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
